load_store_unit: RTL and testbench

Multicycle load/store sequencer for the RV32I core, sitting directly upstream of the shared word-addressed storage block. Takes one byte-addressed load or store per request, drives one read port and the single write port of storage, and returns extended load data. Sub-word stores (SB/SH) are read-modify-write because storage only writes whole rows.

---
 rtl/load_store_unit_pkg.sv | 44 ++++
 rtl/load_store_unit_if.sv | 52 +++++
 rtl/load_store_unit_align.sv | 40 ++++
 rtl/load_store_unit.sv | 99 +++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared types for the RV32I load/store sequencer.
// funct3 codes, FSM state enum, latched request bundle, fault check.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
  } req_t;

  // Unsigned variants have no store form, so they fault as stores.
  function automatic logic is_fault(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic f;
    unique case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = lo[0];
      F3_W:    f = (lo != 2'b00);
      F3_BU:   f = st;
      F3_HU:   f = st | lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshake bundles for the load/store unit.
// lsu_req_if: core (master) <-> LSU (slave); lsu_mem_if: LSU (master) <-> storage (slave).
interface lsu_req_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqIsStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqStoreData;
  logic        respValid;
  logic [31:0] respLoadData;
  logic        respMisaligned;

  modport master (
    output reqValid, reqIsStore, reqFunct3,
    output reqAddr, reqStoreData,
    input  reqReady, respValid,
    input  respLoadData, respMisaligned
  );

  modport slave (
    input  reqValid, reqIsStore, reqFunct3,
    input  reqAddr, reqStoreData,
    output reqReady, respValid,
    output respLoadData, respMisaligned
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 28,
  parameter int ROW_W  = 32
);
  logic [ADDR_W-1:0] memReadAddr;
  logic              memReadEn;
  logic              memReadFin;
  logic [ROW_W-1:0]  memReadData;
  logic [ADDR_W-1:0] memWriteAddr;
  logic [ROW_W-1:0]  memWriteData;
  logic              memWriteEn;

  modport master (
    output memReadAddr, memReadEn,
    input  memReadFin, memReadData,
    output memWriteAddr, memWriteData, memWriteEn
  );

  modport slave (
    input  memReadAddr, memReadEn,
    output memReadFin, memReadData,
    input  memWriteAddr, memWriteData, memWriteEn
  );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational load extract/extend and sub-word store merge.
// row_i/funct3_i/lane_i/wdata_i in; rdata_o (load result), wrow_o (row to write) out.
import load_store_unit_pkg::*;

module lsu_align (
  input  logic [31:0] row_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wrow_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = row_i[{lane_i, 3'b000} +: 8];
    half_w = lane_i[1] ? row_i[31:16] : row_i[15:0];

    unique case (funct3_i)
      F3_B:    rdata_o = {{24{byte_w[7]}}, byte_w};
      F3_H:    rdata_o = {{16{half_w[15]}}, half_w};
      F3_BU:   rdata_o = {24'h0, byte_w};
      F3_HU:   rdata_o = {16'h0, half_w};
      default: rdata_o = row_i;
    endcase

    wrow_o = row_i;
    unique case (funct3_i)
      F3_B: wrow_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (lane_i[1]) wrow_o[31:16] = wdata_i[15:0];
        else           wrow_o[15:0]  = wdata_i[15:0];
      end
      default: wrow_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle RV32I load/store sequencer over word storage.
// clk, rst (sync, high); req: lsu_req_if.slave; mem: lsu_mem_if.master.
import load_store_unit_pkg::*;

module load_store_unit #(
  parameter int READ_ADDR_SIZE = 28,
  parameter int ROW_WIDTH      = 32
) (
  input  logic           clk,
  input  logic           rst,
  lsu_req_if.slave       req,
  lsu_mem_if.master      mem
);

  state_t               state_q, state_d;
  req_t                 req_q, req_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;

  logic        fault_w;
  logic [31:0] ld_w;
  logic [31:0] st_w;
  logic        resp_w;
  logic        unused_hi;

  assign fault_w = is_fault(req.reqIsStore,
                            req.reqFunct3,
                            req.reqAddr[1:0]);
  assign unused_hi = ^req_q.addr[31:READ_ADDR_SIZE+2];

  lsu_align u_align (
    .row_i    (row_q),
    .funct3_i (req_q.funct3),
    .lane_i   (req_q.addr[1:0]),
    .wdata_i  (req_q.data),
    .rdata_o  (ld_w),
    .wrow_o   (st_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    row_d   = row_q;
    unique case (state_q)
      S_IDLE: begin
        if (req.reqValid) begin
          req_d.is_store = req.reqIsStore;
          req_d.funct3   = req.reqFunct3;
          req_d.addr     = req.reqAddr;
          req_d.data     = req.reqStoreData;
          req_d.mis      = fault_w;
          if (fault_w)
            state_d = S_RESP;
          else if (req.reqIsStore && req.reqFunct3 == F3_W)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        if (mem.memReadFin) begin
          row_d   = mem.memReadData;
          state_d = req_q.is_store ? S_WRITE : S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Storage strobes and response are suppressed while rst is high so an
  // abandoned operation never touches storage or reports completion.
  always_comb begin
    resp_w             = (state_q == S_RESP) && !rst;
    req.reqReady       = (state_q == S_IDLE);
    req.respValid      = resp_w;
    req.respMisaligned = resp_w && req_q.mis;
    req.respLoadData   = (resp_w && !req_q.is_store && !req_q.mis)
                         ? ld_w : 32'h0;
    mem.memReadEn      = (state_q == S_READ) && !rst;
    mem.memWriteEn     = (state_q == S_WRITE) && !rst;
    mem.memReadAddr    = req_q.addr[READ_ADDR_SIZE+1:2];
    mem.memWriteAddr   = req_q.addr[READ_ADDR_SIZE+1:2];
    mem.memWriteData   = (req_q.funct3 == F3_W) ? req_q.data : st_w;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench with response scoreboard for load_store_unit.
// Storage is a 16-row model with a stallable read grant.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fin = 1'b1;
  logic preload = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  exp_t q[$];
  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  lsu_req_if rq();
  lsu_mem_if #(.ADDR_W(28), .ROW_W(32)) mi();

  load_store_unit #(.READ_ADDR_SIZE(28), .ROW_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .req (rq.slave),
    .mem (mi.master)
  );

  logic unused_hi;
  assign unused_hi = ^{mi.memReadAddr[27:4], mi.memWriteAddr[27:4]};
  assign mi.memReadData = mem[mi.memReadAddr[3:0]];
  assign mi.memReadFin  = fin;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mi.memReadEn)  rd_cnt <= rd_cnt + 1;
    if (mi.memWriteEn) wr_cnt <= wr_cnt + 1;
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hCAFE_F00D;
      mem[1] <= 32'h8077_F0AB;
      mem[3] <= 32'hAABB_CCDD;
    end else if (mi.memWriteEn) begin
      mem[mi.memWriteAddr[3:0]] <= mi.memWriteData;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every respValid pulse must match the oldest entry.
  always @(negedge clk) begin
    if (rq.respValid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_data"}, rq.respLoadData, e.data);
        chk({e.tag, "_mis"}, {31'h0, rq.respMisaligned}, {31'h0, e.mis});
        chk({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(bit st, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] d, bit has_resp, logic [31:0] ed,
                       bit em, int lat, string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, rq.reqReady}, 32'h1);
    rq.reqValid     = 1'b1;
    rq.reqIsStore   = st;
    rq.reqFunct3    = f3;
    rq.reqAddr      = a;
    rq.reqStoreData = d;
    if (has_resp) begin
      e.data = ed;
      e.mis  = em;
      e.cyc  = cyc + lat;
      e.tag  = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    rq.reqValid = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (n < 40 && !(q.size() == 0 && rq.reqReady === 1'b1)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n, (n < 40) ? n : 0);
    if (n >= 40) q.delete();
  endtask

  initial begin
    int r0, w0;
    rq.reqValid     = 1'b0;
    rq.reqIsStore   = 1'b0;
    rq.reqFunct3    = 3'b000;
    rq.reqAddr      = 32'h0;
    rq.reqStoreData = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, rq.reqReady}, 32'h1);
    chk("rst_resp", {31'h0, rq.respValid}, 32'h0);
    chk("rst_mis", {31'h0, rq.respMisaligned}, 32'h0);
    chk("rst_data", rq.respLoadData, 32'h0);
    chk("rst_ren", {31'h0, mi.memReadEn}, 32'h0);
    chk("rst_wen", {31'h0, mi.memWriteEn}, 32'h0);
    preload = 1'b0;
    rst = 1'b0;

    issue(0, 3'b000, 32'h7, 0, 1, 32'hFFFF_FF80, 0, 2, "lb7");
    wait_done("lb7");
    issue(0, 3'b100, 32'h4, 0, 1, 32'h0000_00AB, 0, 2, "lbu4");
    wait_done("lbu4");
    issue(0, 3'b001, 32'h4, 0, 1, 32'hFFFF_F0AB, 0, 2, "lh4");
    wait_done("lh4");
    issue(0, 3'b101, 32'h6, 0, 1, 32'h0000_8077, 0, 2, "lhu6");
    wait_done("lhu6");

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 3'b010, 32'h8, 32'h1234_5678, 1, 0, 0, 2, "sw8");
    wait_done("sw8");
    chk("sw8_reads", rd_cnt - r0, 0);
    chk("sw8_writes", wr_cnt - w0, 1);
    issue(0, 3'b010, 32'h8, 0, 1, 32'h1234_5678, 0, 2, "lw8");
    wait_done("lw8");

    issue(1, 3'b000, 32'hD, 32'hFFFF_FF11, 1, 0, 0, 3, "sbD");
    wait_done("sbD");
    chk("sbD_mem", mem[3], 32'hAABB_11DD);
    issue(1, 3'b001, 32'hE, 32'hFFFF_2233, 1, 0, 0, 3, "shE");
    wait_done("shE");
    chk("shE_mem", mem[3], 32'h2233_11DD);

    fin = 1'b0;
    issue(0, 3'b010, 32'h0, 0, 1, 32'hCAFE_F00D, 0, 6, "lw0stall");
    repeat (4) begin
      @(negedge clk);
      chk("stall_raddr", {4'h0, mi.memReadAddr}, 32'h0);
      chk("stall_ren", {31'h0, mi.memReadEn}, 32'h1);
    end
    @(negedge clk);
    fin = 1'b1;
    wait_done("lw0stall");

    r0 = rd_cnt; w0 = wr_cnt;
    issue(0, 3'b001, 32'h3, 0, 1, 32'h0, 1, 1, "lh3");
    wait_done("lh3");
    issue(1, 3'b010, 32'h2, 32'hDEAD_BEEF, 1, 32'h0, 1, 1, "sw2");
    wait_done("sw2");
    issue(0, 3'b011, 32'h0, 0, 1, 32'h0, 1, 1, "ld011");
    wait_done("ld011");
    chk("fault_reads", rd_cnt - r0, 0);
    chk("fault_writes", wr_cnt - w0, 0);
    chk("fault_mem0", mem[0], 32'hCAFE_F00D);

    w0 = wr_cnt;
    issue(1, 3'b000, 32'hC, 32'h55, 0, 0, 0, 0, "sbrst");
    @(posedge clk);
    #1;
    chk("sbrst_busy", {31'h0, rq.reqReady}, 32'h0);
    rst = 1'b1;
    #1;
    chk("sbrst_wen", {31'h0, mi.memWriteEn}, 32'h0);
    chk("sbrst_resp", {31'h0, rq.respValid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("sbrst_ready", {31'h0, rq.reqReady}, 32'h1);
    repeat (3) @(negedge clk);
    chk("sbrst_writes", wr_cnt - w0, 0);
    chk("sbrst_mem", mem[3], 32'h2233_11DD);

    issue(0, 3'b010, 32'hC, 0, 1, 32'h2233_11DD, 0, 2, "lwC");
    wait_done("lwC");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
